// File: rtl/i2c_byte_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// i2c_byte_ctrl_pkg
//   Shared definitions for the I2C byte-level controller:
//     - bit_cmd_e : one-hot bit commands sent to the bit-level controller
//     - state_e   : byte FSM state encodings
//     - BYTE_W / TIMER_SIZE : byte width and bit-count timer width
// ---------------------------------------------------------------------------
package i2c_byte_ctrl_pkg;

    localparam int BYTE_W     = 8;
    localparam int TIMER_SIZE = 3;

    typedef enum logic [3:0] {
        BC_NOP   = 4'b0000,
        BC_START = 4'b0001,
        BC_STOP  = 4'b0010,
        BC_WRITE = 4'b0100,
        BC_READ  = 4'b1000
    } bit_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } state_e;

endpackage

// File: rtl/i2c_byte_ctrl_state_timer.sv
// ---------------------------------------------------------------------------
// i2c_byte_state_timer
//   Count-down timer that tracks how many data bits of the current byte are
//   still outstanding. Load sets the count to all ones (7 for SIZE = 3); each
//   Ack decrements it until it reaches zero. Out is high while the count is
//   zero, i.e. while the last bit of the byte is in flight.
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     i_load     : reload pulse from the byte FSM
//     i_ack      : decrement strobe (qualified bit acknowledge)
//     o_out      : count is zero (last bit)
// ---------------------------------------------------------------------------
module i2c_byte_state_timer #(
    parameter int SIZE = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_ack,
    output logic o_out
);

    logic [SIZE-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '1;
        end else if (i_ack && (r_count != '0)) begin
            r_count <= r_count - SIZE'(1);
        end
    end

    assign o_out = (r_count == '0);

endmodule

// File: rtl/i2c_byte_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_byte_ctrl
//   Byte-level controller of the I2C master. Turns byte commands (START,
//   WRITE, READ, STOP, ACK value) into a sequence of single-bit commands for
//   the bit-level controller, shifting one byte out or in MSB first.
//
//   Optional feature macro: I2C_BYTE_AL_EN
//     defined     : Al aborts any active command (Cmd_ack + Al_out pulse)
//     not defined : Al ignored, o_al_out tied low
//
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     i_start/i_stop        : START before / STOP after the byte
//     i_write/i_read        : transmit i_din / receive into o_dout
//     i_ack_in              : ACK bit driven after a READ (0 = ACK)
//     i_din  [7:0]          : byte to transmit
//     o_dout [7:0]          : received byte (shift register)
//     o_ack_out             : ACK bit sampled from the slave
//     o_cmd_ack             : one-cycle completion strobe
//     o_busy                : FSM not idle
//     o_al_out              : one-cycle arbitration-lost strobe
//     o_bit_cmd [3:0]       : bit command to the bit controller
//     o_bit_din             : bit to transmit with a WRITE bit command
//     i_bit_ack             : bit command done (pulse)
//     i_bit_dout            : bit sampled by the bit controller
//     i_al                  : arbitration lost from the bit controller
// ---------------------------------------------------------------------------
module i2c_byte_ctrl
    import i2c_byte_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_write,
    input  logic              i_read,
    input  logic              i_ack_in,
    input  logic [BYTE_W-1:0] i_din,
    output logic [BYTE_W-1:0] o_dout,
    output logic              o_ack_out,
    output logic              o_cmd_ack,
    output logic              o_busy,
    output logic              o_al_out,
    output logic [3:0]        o_bit_cmd,
    output logic              o_bit_din,
    input  logic              i_bit_ack,
    input  logic              i_bit_dout,
    input  logic              i_al
);

    state_e            r_state;
    bit_cmd_e          r_bit_cmd;
    logic              r_bit_din;
    logic [BYTE_W-1:0] r_sr;
    logic              r_ack_out;
    logic              r_cmd_ack;
    logic              r_busy;

    logic w_accept;
    logic w_timer_load;
    logic w_timer_ack;
    logic w_timer_out;

    // A command is only taken while Cmd_ack is low, so a host still holding
    // its inputs during the completion cycle cannot relaunch the same byte.
    assign w_accept = !r_cmd_ack && (i_start || i_stop || i_write || i_read);

    // Reload on accept and when START hands over to the data phase.
    assign w_timer_load = ((r_state == ST_IDLE)  && w_accept) ||
                          ((r_state == ST_START) && i_bit_ack);

    assign w_timer_ack  = i_bit_ack && !w_timer_out &&
                          ((r_state == ST_WRITE) || (r_state == ST_READ));

    i2c_byte_state_timer #(
        .SIZE (TIMER_SIZE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_timer_load),
        .i_ack  (w_timer_ack),
        .o_out  (w_timer_out)
    );

`ifdef I2C_BYTE_AL_EN
    logic r_al_out;
`else
    logic w_unused_al;
    assign w_unused_al = i_al;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cmd <= BC_NOP;
            r_bit_din <= 1'b0;
            r_sr      <= '0;
            r_ack_out <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_busy    <= 1'b0;
`ifdef I2C_BYTE_AL_EN
            r_al_out  <= 1'b0;
`endif
        end else begin
            r_cmd_ack <= 1'b0;
`ifdef I2C_BYTE_AL_EN
            r_al_out  <= 1'b0;
            // Arbitration loss overrides any simultaneous Bit_ack; the shift
            // register and Ack_out keep their values.
            if ((r_state != ST_IDLE) && i_al) begin
                r_state   <= ST_IDLE;
                r_bit_cmd <= BC_NOP;
                r_cmd_ack <= 1'b1;
                r_al_out  <= 1'b1;
                r_busy    <= 1'b0;
            end else
`endif
            begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_busy <= 1'b1;
                            r_sr   <= i_din;
                            if (i_start) begin
                                r_state   <= ST_START;
                                r_bit_cmd <= BC_START;
                            end else if (i_read) begin
                                r_state   <= ST_READ;
                                r_bit_cmd <= BC_READ;
                            end else if (i_write) begin
                                r_state   <= ST_WRITE;
                                r_bit_cmd <= BC_WRITE;
                                r_bit_din <= i_din[BYTE_W-1];
                            end else begin
                                r_state   <= ST_STOP;
                                r_bit_cmd <= BC_STOP;
                            end
                        end
                    end

                    ST_START: begin
                        if (i_bit_ack) begin
                            if (i_read) begin
                                r_state   <= ST_READ;
                                r_bit_cmd <= BC_READ;
                            end else if (i_write) begin
                                r_state   <= ST_WRITE;
                                r_bit_cmd <= BC_WRITE;
                                r_bit_din <= r_sr[BYTE_W-1];
                            end else begin
                                r_state   <= ST_STOP;
                                r_bit_cmd <= BC_STOP;
                            end
                        end
                    end

                    ST_WRITE, ST_READ: begin
                        if (i_bit_ack) begin
                            r_sr <= {r_sr[BYTE_W-2:0], i_bit_dout};
                            if (!w_timer_out) begin
                                // Same bit command stays on o_bit_cmd; the
                                // next MSB is the bit about to shift up.
                                r_bit_din <= r_sr[BYTE_W-2];
                            end else begin
                                r_state <= ST_ACK;
                                if (r_state == ST_WRITE) begin
                                    r_bit_cmd <= BC_READ;
                                end else begin
                                    r_bit_cmd <= BC_WRITE;
                                    r_bit_din <= i_ack_in;
                                end
                            end
                        end
                    end

                    ST_ACK: begin
                        if (i_bit_ack) begin
                            r_ack_out <= i_bit_dout;
                            if (i_stop) begin
                                r_state   <= ST_STOP;
                                r_bit_cmd <= BC_STOP;
                            end else begin
                                r_state   <= ST_IDLE;
                                r_bit_cmd <= BC_NOP;
                                r_cmd_ack <= 1'b1;
                                r_busy    <= 1'b0;
                            end
                        end
                    end

                    ST_STOP: begin
                        if (i_bit_ack) begin
                            r_state   <= ST_IDLE;
                            r_bit_cmd <= BC_NOP;
                            r_cmd_ack <= 1'b1;
                            r_busy    <= 1'b0;
                        end
                    end

                    default: begin
                        r_state   <= ST_IDLE;
                        r_bit_cmd <= BC_NOP;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_dout    = r_sr;
    assign o_ack_out = r_ack_out;
    assign o_cmd_ack = r_cmd_ack;
    assign o_busy    = r_busy;
    assign o_bit_cmd = r_bit_cmd;
    assign o_bit_din = r_bit_din;
`ifdef I2C_BYTE_AL_EN
    assign o_al_out  = r_al_out;
`else
    assign o_al_out  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_byte_ctrl
//   Self-checking bench for i2c_byte_ctrl. A table of byte commands with
//   hand-written expected bit-command sequences is replayed against a simple
//   bit-controller/slave model, followed by hand sequences for reset in the
//   middle of a byte and arbitration loss (expectations follow
//   I2C_BYTE_AL_EN).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_byte_ctrl;

    localparam logic [3:0] C_NOP   = 4'h0;
    localparam logic [3:0] C_START = 4'h1;
    localparam logic [3:0] C_STOP  = 4'h2;
    localparam logic [3:0] C_WRITE = 4'h4;
    localparam logic [3:0] C_READ  = 4'h8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start, i_stop, i_write, i_read, i_ack_in;
    logic [7:0] i_din;
    logic [7:0] o_dout;
    logic       o_ack_out, o_cmd_ack, o_busy, o_al_out;
    logic [3:0] o_bit_cmd;
    logic       o_bit_din;
    logic       i_bit_ack, i_bit_dout, i_al;

    i2c_byte_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_write    (i_write),
        .i_read     (i_read),
        .i_ack_in   (i_ack_in),
        .i_din      (i_din),
        .o_dout     (o_dout),
        .o_ack_out  (o_ack_out),
        .o_cmd_ack  (o_cmd_ack),
        .o_busy     (o_busy),
        .o_al_out   (o_al_out),
        .o_bit_cmd  (o_bit_cmd),
        .o_bit_din  (o_bit_din),
        .i_bit_ack  (i_bit_ack),
        .i_bit_dout (i_bit_dout),
        .i_al       (i_al)
    );

    always #5 clk = ~clk;

    // One byte command with its expected bit-command trace. cmds holds n
    // nibbles right-justified, first command in the most significant nibble;
    // dins holds the expected Bit_din per command the same way (only checked
    // for WRITE bit commands).
    typedef struct {
        logic        start, stop, write, read, ack_in;
        logic [7:0]  din;
        logic [7:0]  slave_byte;
        logic        slave_ack;
        int          n;
        logic [63:0] cmds;
        logic [15:0] dins;
        logic        chk_data;
        logic [7:0]  exp_dout;
        logic        exp_ack;
    } vec_t;

    vec_t vecs [7];
    vec_t v_rst, v_after;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations from the last run_vec call.
    logic [3:0] rec_cmd [16];
    logic       rec_din [16];
    int         rec_n, n_cmd_ack, n_al, cyc_last_ack, cyc_cmd_ack;
    logic [3:0] first_cmd, ack_bit_cmd;
    logic       first_busy, ack_busy, ack_al, rst_hit;
    logic [7:0] ack_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drop_cmds();
        i_start = 1'b0; i_stop = 1'b0; i_write = 1'b0; i_read = 1'b0;
    endtask

    // Drives one byte command, answers every bit command two cycles after it
    // appears, and holds the command inputs one cycle past Cmd_ack.
    task automatic run_vec(input vec_t v, input int al_at, input int rst_at);
        int   gap;
        int   rd_cnt;
        logic resp;
        gap = 0; rd_cnt = 0; rec_n = 0; n_cmd_ack = 0; n_al = 0;
        cyc_last_ack = -10; cyc_cmd_ack = -10; rst_hit = 1'b0;
        ack_dout = 8'h00; ack_busy = 1'b1; ack_bit_cmd = 4'hF; ack_al = 1'b0;
        i_start = v.start; i_stop = v.stop; i_write = v.write; i_read = v.read;
        i_ack_in = v.ack_in; i_din = v.din;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                first_cmd  = o_bit_cmd;
                first_busy = o_busy;
            end
            if (o_al_out) n_al++;
            if (o_cmd_ack) begin
                n_cmd_ack++;
                if (n_cmd_ack == 1) begin
                    cyc_cmd_ack = cyc;
                    ack_dout    = o_dout;
                    ack_busy    = o_busy;
                    ack_bit_cmd = o_bit_cmd;
                    ack_al      = o_al_out;
                end
            end
            if (i_bit_ack || i_al) begin
                i_bit_ack = 1'b0; i_al = 1'b0; i_bit_dout = 1'b0; gap = 0;
            end else if (n_cmd_ack == 0 && o_bit_cmd != C_NOP) begin
                gap++;
                if (gap == 2) begin
                    if (rec_n < 16) begin
                        rec_cmd[rec_n] = o_bit_cmd;
                        rec_din[rec_n] = o_bit_din;
                    end
                    if (rec_n == rst_at) begin
                        #2 rst_n = 1'b0;
                        #1 rst_hit = 1'b1;
                        return;
                    end
                    if (o_bit_cmd == C_WRITE) begin
                        resp = o_bit_din;
                    end else if (o_bit_cmd == C_READ) begin
                        if (v.read && rd_cnt < 8) begin
                            resp = v.slave_byte[7 - rd_cnt];
                            rd_cnt++;
                        end else begin
                            resp = v.slave_ack;
                        end
                    end else begin
                        resp = 1'b0;
                    end
                    i_bit_dout   = resp;
                    i_bit_ack    = 1'b1;
                    cyc_last_ack = cyc;
                    if (rec_n == al_at) i_al = 1'b1;
                    rec_n++;
                end
            end
            if (n_cmd_ack > 0 && cyc == cyc_cmd_ack + 1) drop_cmds();
            if (n_cmd_ack > 0 && cyc == cyc_cmd_ack + 5) break;
        end
        drop_cmds();
    endtask

    task automatic check_vec(input vec_t v, input string name);
        logic [3:0] exp_c;
        check({name, " cmd_ack count"}, n_cmd_ack, 1);
        check({name, " accept cmd"}, first_cmd, v.cmds[4*(v.n-1) +: 4]);
        check({name, " accept busy"}, first_busy, 1'b1);
        check({name, " bit cmd count"}, rec_n, v.n);
        for (int i = 0; i < v.n && i < 16; i++) begin
            exp_c = v.cmds[4*(v.n-1-i) +: 4];
            check($sformatf("%s cmd%0d", name, i), rec_cmd[i], exp_c);
            if (exp_c == C_WRITE)
                check($sformatf("%s din%0d", name, i), rec_din[i], v.dins[v.n-1-i]);
        end
        check({name, " cmd_ack latency"}, cyc_cmd_ack - cyc_last_ack, 1);
        check({name, " busy at cmd_ack"}, ack_busy, 1'b0);
        check({name, " nop at cmd_ack"}, ack_bit_cmd, C_NOP);
        if (v.chk_data) begin
            check({name, " dout"}, ack_dout, v.exp_dout);
            check({name, " ack_out"}, o_ack_out, v.exp_ack);
        end
        check({name, " al_out pulses"}, n_al, 0);
        check({name, " no relaunch busy"}, o_busy, 1'b0);
        check({name, " no relaunch cmd"}, o_bit_cmd, C_NOP);
    endtask

    function automatic vec_t mk(input logic st, sp, wr, rd, ai, input logic [7:0] din,
                                input logic [7:0] sb, input logic sa, input int n,
                                input logic [63:0] cmds, input logic [15:0] dins,
                                input logic chk, input logic [7:0] ed, input logic ea);
        vec_t v;
        v.start = st; v.stop = sp; v.write = wr; v.read = rd; v.ack_in = ai;
        v.din = din; v.slave_byte = sb; v.slave_ack = sa; v.n = n;
        v.cmds = cmds; v.dins = dins; v.chk_data = chk; v.exp_dout = ed; v.exp_ack = ea;
        return v;
    endfunction

    initial begin
        //              st sp wr rd ai din    slave  sa  n   cmds                dins              chk dout   ack
        vecs[0] = mk(1, 0, 1, 0, 0, 8'hA5, 8'h00, 0, 10, 64'h1444444448,   16'b0101001010,   1, 8'hA5, 0);
        vecs[1] = mk(0, 1, 0, 1, 1, 8'h00, 8'h3C, 0, 10, 64'h8888888842,   16'b0000000010,   1, 8'h3C, 1);
        vecs[2] = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1,  64'h2,            16'b0,            0, 8'h00, 0);
        vecs[3] = mk(1, 0, 1, 1, 0, 8'h5A, 8'h81, 0, 10, 64'h1888888884,   16'b0,            1, 8'h81, 0);
        vecs[4] = mk(0, 0, 1, 0, 0, 8'hFF, 8'h00, 0, 9,  64'h444444448,    16'b111111110,    1, 8'hFF, 0);
        vecs[5] = mk(0, 0, 0, 1, 0, 8'hFF, 8'h00, 0, 9,  64'h888888884,    16'b0,            1, 8'h00, 0);
        vecs[6] = mk(1, 1, 1, 0, 0, 8'h3C, 8'h00, 1, 11, 64'h14444444482,  16'b00011110000,  1, 8'h3C, 1);
        v_rst   = mk(0, 0, 0, 1, 0, 8'h77, 8'hC3, 0, 9,  64'h888888884,    16'b0,            0, 8'h00, 0);
        v_after = vecs[4];

        rst_n = 1'b0;
        drop_cmds();
        i_ack_in = 1'b0; i_din = 8'h00;
        i_bit_ack = 1'b0; i_bit_dout = 1'b0; i_al = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset bit_cmd", o_bit_cmd, C_NOP);
        check("reset busy", o_busy, 1'b0);
        check("reset dout", o_dout, 8'h00);
        check("reset ack_out", o_ack_out, 1'b0);
        check("reset cmd_ack", o_cmd_ack, 1'b0);
        check("reset bit_din", o_bit_din, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Bit_ack while idle must be ignored.
        i_bit_ack = 1'b1;
        @(posedge clk); #1;
        i_bit_ack = 1'b0;
        check("idle bit_ack busy", o_busy, 1'b0);
        check("idle bit_ack cmd_ack", o_cmd_ack, 1'b0);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], -1, -1);
            check_vec(vecs[k], $sformatf("vec%0d", k));
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset during the 5th READ bit; vec6 left Ack_out = 1.
        run_vec(v_rst, -1, 4);
        check("rst reached", rst_hit, 1'b1);
        check("rst bit_cmd", o_bit_cmd, C_NOP);
        check("rst bit_din", o_bit_din, 1'b0);
        check("rst dout", o_dout, 8'h00);
        check("rst ack_out", o_ack_out, 1'b0);
        check("rst busy", o_busy, 1'b0);
        check("rst cmd_ack", o_cmd_ack, 1'b0);
        check("rst al_out", o_al_out, 1'b0);
        drop_cmds();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(v_after, -1, -1);
        check_vec(v_after, "after_rst");
        repeat (2) @(posedge clk);
        #1;

        // Arbitration loss together with Bit_ack on the 4th WRITE bit.
        run_vec(vecs[0], 4, -1);
`ifdef I2C_BYTE_AL_EN
        check("al cmd_ack count", n_cmd_ack, 1);
        check("al bit cmds", rec_n, 5);
        check("al cmd_ack latency", cyc_cmd_ack - cyc_last_ack, 1);
        check("al al_out with cmd_ack", ack_al, 1'b1);
        check("al al_out pulses", n_al, 1);
        check("al nop", ack_bit_cmd, C_NOP);
        check("al busy", ack_busy, 1'b0);
        check("al dout kept", ack_dout, 8'h2D);
        check("al ack_out kept", o_ack_out, 1'b0);
        check("al idle after", o_busy, 1'b0);
`else
        check_vec(vecs[0], "al_ignored");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_byte_ctrl.md
# i2c_byte_ctrl

Byte-level controller of the I2C master control unit. Accepts byte commands (START, WRITE, READ, STOP, ACK value) from the register interface and sequences them into single-bit commands for the bit-level controller. It serialises or deserialises one byte with an internal shift register and a bit-state count-down timer. It returns the received byte, the slave ACK bit and a one-cycle completion strobe.

## Interface
- No parameters; byte width fixed at 8.
- Clk  in  1  system clock, all state on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  generate START/repeated START before the byte
- Stop  in  1  generate STOP after the byte (or alone)
- Write  in  1  transmit Din
- Read  in  1  receive a byte into Dout
- Ack_in  in  1  ACK bit to drive after a READ (0 = ACK, 1 = NACK)
- Din  in  8  byte to transmit, MSB first
- Dout  out  8  received byte
- Ack_out  out  1  ACK bit sampled from slave after WRITE
- Cmd_ack  out  1  one-cycle pulse: byte command complete
- Busy  out  1  high whenever state ≠ IDLE
- Al_out  out  1  one-cycle pulse: arbitration lost, command aborted
- Bit_cmd  out  4  bit command: NOP=0000, START=0001, STOP=0010, WRITE=0100, READ=1000
- Bit_din  out  1  bit to transmit with WRITE bit command
- Bit_ack  in  1  one-cycle pulse from bit controller: current bit command done
- Bit_dout  in  1  bit sampled by bit controller (valid with Bit_ack)
- Al  in  1  arbitration-lost flag from bit controller

## Operation
- States: IDLE, START, WRITE, READ, ACK, STOP; registered FSM.
- IDLE: if Cmd_ack low and any command input high, Busy rises. Load shift register with Din; pulse timer Load (count = 7). Priority: Start → START (Bit_cmd START); else Read → READ (Bit_cmd READ); else Write → WRITE (Bit_cmd WRITE, Bit_din = Din[7]); else Stop → STOP (Bit_cmd STOP).
- START, on Bit_ack: Read → READ; else Write → WRITE; else (Stop only) → STOP. Timer reloaded.
- WRITE/READ, on Bit_ack: shift register shifts left, LSB ← Bit_dout. If timer Out low: timer decrements, same bit command reissued, Bit_din = new MSB. If timer Out high (8th bit): → ACK. WRITE issues Bit_cmd READ; READ issues Bit_cmd WRITE with Bit_din = Ack_in.
- ACK, on Bit_ack: Ack_out ← Bit_dout. Then Stop → STOP (Bit_cmd STOP); else → IDLE with Cmd_ack pulse, Bit_cmd NOP.
- STOP, on Bit_ack: → IDLE, Cmd_ack pulse, Bit_cmd NOP.
- Dout = shift register contents; valid from the Cmd_ack cycle of a READ until next command accept.
- Al high in any non-IDLE state: → IDLE next cycle, Bit_cmd NOP, Cmd_ack and Al_out pulse together, Dout/Ack_out unchanged.

## Timing
- Reset values: state IDLE, Bit_cmd 0000, Bit_din 0, Dout 00h, Ack_out 0, Cmd_ack 0, Al_out 0, Busy 0, timer 0.
- All outputs registered; Bit_cmd held stable until Bit_ack.
- Command accept latency: 1 cycle (Bit_cmd valid the cycle after command seen in IDLE).
- Cmd_ack asserted exactly one cycle after the final Bit_ack.
- Host holds command inputs until Cmd_ack; commands seen while Cmd_ack = 1 are ignored, so the same command never relaunches.
- Bit_ack while in IDLE: ignored.
- Al and Bit_ack in same cycle: Al wins.
- Reset mid-byte: immediate return to reset values; partial byte discarded.

## Configuration
- I2C_BYTE_AL_EN defined: arbitration-lost abort as described.
- Not defined: Al input ignored, Al_out tied 0, no abort path.

## Structure
- Shared package/include (i2c_defines.v): bit command codes, FSM state encodings.
- One sub-module: i2c_byte_state_timer, SIZE = 3. Load ← FSM load pulse; Ack ← Bit_ack qualified by WRITE/READ state with Out low; Out → last-bit detect.

## Test plan
- Start+Write, Din = A5h, slave ACK = 0: Bit_cmd sequence START, 8×WRITE with Bit_din 1,0,1,0,0,1,0,1, then READ. Cmd_ack once; Ack_out = 0.
- Read+Ack_in=1+Stop, slave bits 3Ch: 8×READ, WRITE with Bit_din = 1, STOP. Dout = 3Ch at Cmd_ack.
- Stop only: single STOP bit command, Cmd_ack one cycle after its Bit_ack, Busy low next.
- Al asserted on the 4th WRITE bit (macro defined): IDLE next cycle, Cmd_ack and Al_out pulse, Bit_cmd = NOP. With macro undefined: byte completes normally.
- Rst_n low during the 5th READ bit: all outputs at reset values asynchronously; after release, a new Write completes normally.
- Start, Read and Write held together: READ path taken (priority). Host holds commands through Cmd_ack: no second launch.
